// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: streaming adder/subtractor built from GROUP-bit
// carry-lookahead blocks, one register stage per group. The carry moves one
// group per clock. Operand skew and sum deskew registers travel alongside it,
// so a finished result leaves as one aligned beat. The whole pipe advances
// together under a single valid/ready handshake.
// Optional build macro: CLA_SAT_EN (saturate sum on signed overflow).

// One lookahead group: a flat sum-of-products carry for every bit position.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co
);
  logic [GROUP-1:0] g, p;
  logic [GROUP:0]   c;
  logic             t, acc;

  // Each carry is expanded directly from g/p/ci and does not ripple.
  always_comb begin
    g   = a & b;
    p   = a ^ b;
    c   = '0;
    t   = 1'b0;
    acc = 1'b0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      t = ci;
      for (int j = 0; j <= i; j++) t = t & p[j];
      acc = t;
      for (int j = 0; j <= i; j++) begin
        t = g[j];
        for (int m = j + 1; m <= i; m++) t = t & p[m];
        acc = acc | t;
      end
      c[i+1] = acc;
    end
    s  = p ^ c[GROUP-1:0];
    co = c[GROUP];
  end
endmodule

module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / GROUP;

  logic                        adv;
  logic [STAGES:0]             vld_pipe;
  logic [WIDTH-1:0]            a_q   [STAGES];
  logic [WIDTH-1:0]            b_q   [STAGES];
  logic [WIDTH-1:0]            s_q   [STAGES];
  logic [WIDTH-1:0]            snx   [STAGES];
  logic [STAGES-1:0]           c_q;
  logic [STAGES-1:0]           gco;
  logic [STAGES-1:0][GROUP-1:0] gs;
  logic [WIDTH-1:0]            raw, sum_nx;
  logic                        cmsb, ovf_nx;

  // A stalled output freezes the entire pipe. Bubbles are never squeezed out.
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[STAGES];

  // Stage k resolves group k of the operands it holds.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_group #(.GROUP(GROUP)) u_cla (
      .a  (a_q[k][GROUP*k +: GROUP]),
      .b  (b_q[k][GROUP*k +: GROUP]),
      .ci (c_q[k]),
      .s  (gs[k]),
      .co (gco[k])
    );
  end

  // Merge each stage's fresh group into the sum bits resolved so far.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      snx[k] = s_q[k];
      snx[k][GROUP*k +: GROUP] = gs[k];
    end
  end

  // Final stage: overflow, and optional saturation of the result.
  // carry into MSB = p ^ s at the MSB, where p = a ^ b.
  always_comb begin
    raw    = snx[STAGES-1];
    cmsb   = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1] ^ raw[WIDTH-1];
    ovf_nx = gco[STAGES-1] ^ cmsb;
    sum_nx = raw;
`ifdef CLA_SAT_EN
    // A wrapped MSB of 1 means the true result is positive, and 0 means negative.
    if (ovf_nx) sum_nx = {~raw[WIDTH-1], {(WIDTH-1){raw[WIDTH-1]}}};
`endif
  end

  // Pipe registers shift one stage on every advance. Entry inverts B for subtract.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      c_q      <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
      a_q[0]   <= a;
      b_q[0]   <= sub ? ~b : b;
      c_q[0]   <= sub | cin;
      s_q[0]   <= '0;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        c_q[k] <= gco[k-1];
        s_q[k] <= snx[k-1];
      end
      sum  <= sum_nx;
      cout <= gco[STAGES-1];
      ovf  <= ovf_nx;
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=16, GROUP=4). Uses a table of vectors,
// random streaming with backpressure, and reset mid-flight. Expected results
// go into a scoreboard queue on acceptance and are popped when the output
// handshakes.
module tb_pipelined_cla_adder;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;
  typedef struct {
    logic [15:0] s;
    logic        co, ov;
  } exp_t;

  exp_t sb[$];
  exp_t cur_exp, pop_e;
  vec_t tv[9];
  int   checks = 0, fails = 0;
  int   cyc;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] ai, input logic [15:0] bi,
                                 input logic ci, input logic si);
    logic [15:0] bb;
    logic [16:0] r;
    exp_t e;
    bb   = si ? ~bi : bi;
    r    = {1'b0, ai} + {1'b0, bb} + {16'h0, (si ? 1'b1 : ci)};
    e.s  = r[15:0];
    e.co = r[16];
    e.ov = (ai[15] == bb[15]) && (r[15] != ai[15]);
`ifdef CLA_SAT_EN
    if (e.ov) e.s = r[15] ? 16'h7FFF : 16'h8000;
`endif
    return e;
  endfunction

  function automatic vec_t mk(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                              input logic si, input logic [15:0] s, input logic [15:0] ssat,
                              input logic co, input logic ov);
    vec_t v;
    v.a = ai; v.b = bi; v.cin = ci; v.sub = si; v.co = co; v.ov = ov;
`ifdef CLA_SAT_EN
    v.s = ssat;
`else
    v.s = s;
`endif
    return v;
  endfunction

  // Output scoreboard check and input-side push, sampled away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_output: got sum %0h expected no result", sum);
        end else begin
          pop_e = sb.pop_front();
          check("sum", 32'(sum), 32'(pop_e.s));
          check("cout", 32'(cout), 32'(pop_e.co));
          check("ovf", 32'(ovf), 32'(pop_e.ov));
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  // Present one beat and hold it until accepted. Returns just after the accepting edge.
  task automatic drive(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                       input logic si, input exp_t e);
    bit acc;
    int n;
    a = ai; b = bi; cin = ci; sub = si; cur_exp = e; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    exp_t e;
    e.s = v.s; e.co = v.co; e.ov = v.ov;
    drive(v.a, v.b, v.cin, v.sub, e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    //            a        b        cin   sub   sum      sum(sat) cout  ovf
    tv[0] = mk(16'h0001, 16'h0007, 1'b1, 1'b0, 16'h0009, 16'h0009, 1'b0, 1'b0);
    tv[1] = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tv[2] = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1);
    tv[3] = mk(16'h0005, 16'h000A, 1'b1, 1'b1, 16'hFFFB, 16'hFFFB, 1'b0, 1'b0);
    tv[4] = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 16'h8000, 1'b1, 1'b1);
    tv[5] = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1);
    tv[6] = mk(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 16'h5555, 1'b0, 1'b0);
    tv[7] = mk(16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    tv[8] = mk(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 16'h1000, 1'b0, 1'b0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    cur_exp.s = '0; cur_exp.co = 1'b0; cur_exp.ov = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency from the accepting edge to out_valid.
    drive_vec(tv[0]);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd4);
    drain();

    // Table vectors, back-to-back.
    for (int i = 0; i < 9; i++) drive_vec(tv[i]);
    drain();

    // Random stream with a 3-cycle output stall in the middle.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          logic [15:0] ra, rb;
          logic        rc, rs;
          ra = 16'($urandom);
          rb = 16'($urandom);
          rc = 1'($urandom);
          rs = 1'($urandom);
          drive(ra, rb, rc, rs, model(ra, rb, rc, rs));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("stall_out_valid", 32'(out_valid), 32'd1);
          check("stall_in_ready", 32'(in_ready), 32'd0);
          if (sb.size() > 0) begin
            check("stall_sum", 32'(sum), 32'(sb[0].s));
            check("stall_cout", 32'(cout), 32'(sb[0].co));
            check("stall_ovf", 32'(ovf), 32'(sb[0].ov));
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with beats in flight.
    for (int i = 0; i < 3; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      drive(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
    end
    repeat (2) @(posedge clk);
    #1;
    check("preflush_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_idle", {30'd0, out_valid, in_ready}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/pipelined_cla_adder.md
# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor for arbitrary operand width. Operands are split into GROUP-bit lookahead groups with one register stage per group, so the carry moves one group per cycle. Throughput is one operation per clock. A valid/ready handshake at both ends lets the block sit directly in a streaming datapath, between an operand source and a result consumer.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of GROUP, and at least GROUP.
- GROUP, 4, bits per lookahead group; also the number of bits resolved per pipeline stage.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b, computed as a+~b+1; cin ignored).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

One clock; reset is asynchronous and active-high.

## Operation
- Number of stages: STAGES = WIDTH/GROUP.
- Stage k computes sum bits [GROUP*k +: GROUP] with a GROUP-bit CLA.
  - The carry into stage k is the registered carry-out of stage k-1.
  - The carry into stage 0 is cin, or 1 when sub=1.
- Operand bits not yet consumed are carried forward in skew registers.
- Completed sum bits are carried forward in deskew registers, so all of `sum` leaves aligned in one beat.
- B is inverted at entry when sub=1.
- ovf = carry into the MSB XOR carry out of the MSB; it is captured in the final stage.
- Every stage has a valid bit. The whole pipe advances together when adv = !out_valid || out_ready.
  - in_ready = adv.
  - A beat is accepted when in_valid && in_ready.
  - When the pipe advances without an accepted beat, a bubble (valid=0) enters stage 0.
- Ordering: results emerge strictly in acceptance order. There is no reordering, dropping or duplication.
- Stall: while out_valid && !out_ready:
  - sum, cout, ovf and out_valid hold stable;
  - in_ready=0;
  - no internal state changes.
- Bubbles do not collapse; a stalled pipe stays stalled even if inner stages are empty.

## Timing
- Reset values, applied asynchronously and held until the first clk edge after rst deasserts:
  - out_valid=0, sum=0, cout=0, ovf=0;
  - all stage valid bits 0;
  - in_ready=1 (combinational from out_valid=0).
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES. For the defaults, that is 4 cycles.
- Throughput: with out_ready held at 1, back-to-back beats produce back-to-back results.
- out_ready and in_valid may change on any cycle. in_ready depends combinationally on out_ready; there is no combinational path from in_valid to any output.
- Reset mid-operation discards all in-flight beats. After reset releases, no stale result is ever presented.
- A handshake on the same cycle at both ends (accept and emit) is legal and required at full throughput.

## Configuration
- CLA_SAT_EN:
  - Defined: when ovf=1, sum saturates to the signed limit in the direction of the true result. Positive overflow gives 0111…1; negative overflow gives 1000…0. ovf and cout still report the raw condition.
  - Undefined: sum wraps modulo 2^WIDTH.
- The macro affects only the final stage; latency is unchanged.

## Test plan
All scenarios use WIDTH=16, GROUP=4.
- Basic add: a=16'h0001, b=16'h0007, cin=1, sub=0, out_ready=1 -> 4 cycles later sum=16'h0009, cout=0, ovf=0.
- Full carry ripple: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1, ovf=0.
- Signed overflow: a=16'h7FFF, b=16'h0001 -> sum=16'h8000, ovf=1 without CLA_SAT_EN; sum=16'h7FFF, ovf=1 with it.
- Subtract with borrow: a=16'h0005, b=16'h000A, sub=1, cin=1 (ignored) -> sum=16'hFFFB, cout=0, ovf=0.
- Backpressure: stream 8 random beats back-to-back with out_ready low for 3 cycles mid-stream ->
  - in_ready drops in the same cycle that out_valid && !out_ready holds;
  - outputs stay stable while stalled;
  - all 8 results match a reference model, in order.
- Reset mid-flight: accept 3 beats, then assert rst for 1 cycle ->
  - out_valid=0 immediately, without waiting for a clock edge;
  - nothing emerges in the next 10 cycles while in_valid=0;
  - in_ready=1 throughout.
